fifo_write_packer: RTL and testbench
====================================

FIFO_WRITE_PACKER -- requirements
Module: fifo_write_packer

Interface
REQ-001 The block SHALL have parameter IN_WIDTH, default 8, the width of one upstream beat.
REQ-002 The block SHALL have parameter RATIO, default 4, the number of beats packed per FIFO word (2..16).
REQ-003 The block SHALL have parameter CNT_WIDTH, default 16, the width of the written-word counter.
REQ-004 Clocking SHALL be: reset i_arst, asynchronous, active-high; clock i_wclk.
REQ-005 The block SHALL have port i_arst  in  1  asynchronous active-high reset.
REQ-006 The block SHALL have port i_wclk  in  1  write-domain clock.
REQ-007 The block SHALL have port i_valid  in  1  upstream beat valid.
REQ-008 The block SHALL have port o_ready  out  1  upstream beat accepted when i_valid & o_ready.
REQ-009 The block SHALL have port i_data  in  IN_WIDTH  upstream beat.
REQ-010 The block SHALL have port i_flush  in  1  push partial word (active only with macro, REQ-030).
REQ-011 The block SHALL have port i_fifo_full  in  1  full flag from the downstream dual-clock FIFO write side.
REQ-012 The block SHALL have port o_fifo_we  out  1  FIFO write enable.
REQ-013 The block SHALL have port o_fifo_wdata  out  IN_WIDTH*RATIO  FIFO write data.
REQ-014 The block SHALL have port o_word_cnt  out  CNT_WIDTH  count of FIFO writes issued.

Function
REQ-015 Packing SHALL use a lane index 0..RATIO-1: an accepted beat is written into lane idx, bits [idx*IN_WIDTH +: IN_WIDTH], with lane 0 in the LSBs.
REQ-016 On acceptance, idx SHALL increment, wrapping RATIO-1 -> 0.
REQ-017 Acceptance at idx==RATIO-1 SHALL move the completed word (including the current beat) into a one-entry output register and set pend=1 on the next edge.
REQ-018 o_fifo_we SHALL be combinational pend & ~i_fifo_full, and o_fifo_wdata SHALL be the output register.
REQ-019 pend SHALL clear on the edge where o_fifo_we=1, unless a new completed word is loaded on that same edge, in which case pend stays 1 and the register takes the new word.
REQ-020 o_ready SHALL be ~pend | o_fifo_we | (idx != RATIO-1), so the block never drops or overwrites a word.
REQ-021 Latency SHALL be: last beat accepted at cycle N gives o_fifo_we=1 at cycle N+1 if i_fifo_full=0.
REQ-022 Sustained throughput SHALL be 1 beat/cycle while i_fifo_full=0.
REQ-023 While i_fifo_full=1, o_fifo_we SHALL be 0, the pending word SHALL be held, and up to RATIO-1 further beats SHALL still be accepted into the packing register.
REQ-024 o_word_cnt SHALL increment by 1 on each edge with o_fifo_we=1 and SHALL wrap 2^CNT_WIDTH-1 -> 0.
REQ-025 i_valid with o_ready=0 SHALL have no effect, and i_data SHALL be ignored when i_valid=0.

Reset
REQ-026 Asserting i_arst SHALL asynchronously set idx=0, pend=0, the packing and output registers to 0, and o_word_cnt=0.
REQ-027 While in reset, o_fifo_we SHALL be 0, o_ready SHALL be 1 and o_fifo_wdata SHALL be 0.
REQ-028 A reset mid-word SHALL discard the partial and pending words without issuing any write.

Configuration
REQ-029 Macro FIFO_WRITE_PACKER_FLUSH_EN SHALL compile the flush feature in.
REQ-030 With the macro defined, i_flush=1 while idx!=0 (after including any beat accepted in the same cycle) SHALL load the partial word with unfilled lanes zeroed, set pend, and reset idx=0; flush with idx==0 SHALL be a no-op; while a flush would collide with an unwritten pend, o_ready SHALL be 0 and the flush SHALL be held until the pending word is written.
REQ-031 Without the macro, i_flush SHALL be ignored and the flush logic SHALL be absent.

Structure
REQ-032 Shared package fifo_write_packer_pkg SHALL hold the idx-width function (clog2 of RATIO) and the default parameter constants.
REQ-033 The block SHALL be a single module with no sub-module.
REQ-034 o_fifo_we/o_fifo_wdata SHALL connect directly to the FIFO i_we/i_wdata, with i_fifo_full driven from the FIFO o_full.

Verification (IN_WIDTH=8, RATIO=4)
REQ-035 Beats 11,22,33,44 on consecutive cycles with full=0 SHALL give one write of o_fifo_wdata=0x44332211 one cycle after the 44 beat, and o_word_cnt=1.
REQ-036 Holding full=1 with 8 valid beats offered SHALL give first word pending, 3 beats accepted, then o_ready=0; releasing full SHALL give two writes in order with no loss.
REQ-037 Streaming 400 beats with no backpressure SHALL give o_ready constant 1, 100 writes and o_word_cnt=100.
REQ-038 With macro defined, beats AA,BB then flush SHALL give a write of 0x0000BBAA and idx=0; flush at idx=0 SHALL give no write.
REQ-039 Asserting i_arst after 2 beats and while pend=1 SHALL give no write, all outputs at reset values, and the next 4 beats SHALL pack from lane 0.
REQ-040 With CNT_WIDTH=4 and 17 words, o_word_cnt SHALL equal 1.

Source files
------------

// File: rtl/fifo_write_packer_pkg.sv
// Shared constants and helpers for the FIFO write-side beat packer.
package fifo_write_packer_pkg;

  localparam int unsigned DEF_IN_WIDTH  = 8;
  localparam int unsigned DEF_RATIO     = 4;
  localparam int unsigned DEF_CNT_WIDTH = 16;

  // Width of the lane index; never below one bit so the index stays declarable.
  function automatic int unsigned idx_width(input int unsigned ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

endpackage

// File: rtl/fifo_write_packer.sv
// Packs RATIO upstream beats into one word for a dual-clock FIFO write port.
// Optional partial-word flush is compiled in with FIFO_WRITE_PACKER_FLUSH_EN.
module fifo_write_packer
  import fifo_write_packer_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = DEF_IN_WIDTH,
  parameter int unsigned RATIO     = DEF_RATIO,
  parameter int unsigned CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                      i_arst,
  input  logic                      i_wclk,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [IN_WIDTH-1:0]       i_data,
  input  logic                      i_flush,
  input  logic                      i_fifo_full,
  output logic                      o_fifo_we,
  output logic [IN_WIDTH*RATIO-1:0] o_fifo_wdata,
  output logic [CNT_WIDTH-1:0]      o_word_cnt
);

  localparam int unsigned     IDX_W = idx_width(RATIO);
  localparam int unsigned     OUT_W = IN_WIDTH * RATIO;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(RATIO - 1);

  logic [IDX_W-1:0]     r_idx;
  logic [OUT_W-1:0]     r_pack;
  logic [OUT_W-1:0]     r_out;
  logic                 r_pend;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_we;
  logic                 w_stall;
  logic                 w_ready;
  logic                 w_acc;
  logic                 w_complete;
  logic                 w_flush;
  logic                 w_load;
  logic [IDX_W-1:0]     w_idx_nx;
  logic [OUT_W-1:0]     w_pack_nx;

  assign w_we = r_pend & ~i_fifo_full;

`ifdef FIFO_WRITE_PACKER_FLUSH_EN
  // A flush cannot overwrite an unwritten word, so hold beats until it drains.
  assign w_stall = i_flush & r_pend & ~w_we;
`else
  logic w_unused_flush;
  assign w_unused_flush = i_flush;
  assign w_stall        = 1'b0;
`endif

  assign w_ready    = (~r_pend | w_we | (r_idx != LAST)) & ~w_stall;
  assign w_acc      = i_valid & w_ready;
  assign w_complete = w_acc & (r_idx == LAST);
  assign w_idx_nx   = w_acc ? r_idx + IDX_W'(1) : r_idx;

`ifdef FIFO_WRITE_PACKER_FLUSH_EN
  assign w_flush = i_flush & ~w_complete & (w_idx_nx != '0) & ~w_stall;
`else
  assign w_flush = 1'b0;
`endif

  assign w_load = w_complete | w_flush;

  always_comb begin
    w_pack_nx = r_pack;
    for (int unsigned l = 0; l < RATIO; l++) begin
      if (w_acc && (r_idx == IDX_W'(l)))
        w_pack_nx[l*IN_WIDTH +: IN_WIDTH] = i_data;
    end
  end

  // Packing register is cleared on every load, so a flushed word has zero upper lanes.
  always_ff @(posedge i_wclk or posedge i_arst) begin
    if (i_arst) begin
      r_idx  <= '0;
      r_pack <= '0;
      r_out  <= '0;
      r_pend <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (w_load) begin
        r_out  <= w_pack_nx;
        r_pack <= '0;
        r_idx  <= '0;
        r_pend <= 1'b1;
      end else begin
        r_pack <= w_pack_nx;
        r_idx  <= w_idx_nx;
        if (w_we)
          r_pend <= 1'b0;
      end
      if (w_we)
        r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_ready      = w_ready;
  assign o_fifo_we    = w_we;
  assign o_fifo_wdata = r_out;
  assign o_word_cnt   = r_cnt;

endmodule

// File: tb/tb_fifo_write_packer.sv
// Scoreboard bench for fifo_write_packer (IN_WIDTH=8, RATIO=4), plus a CNT_WIDTH=4 copy.
module tb_fifo_write_packer;

  logic        clk = 1'b0;
  logic        arst, valid, flush, full;
  logic [7:0]  data;
  logic        ready, we, ready2, we2;
  logic [31:0] wdata, wdata2;
  logic [15:0] cnt;
  logic [3:0]  cnt2;

  int unsigned total = 0;
  int unsigned bad = 0;
  int unsigned n_writes = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_word;
  int unsigned lane;

  always #5 clk = ~clk;

  fifo_write_packer #(.IN_WIDTH(8), .RATIO(4), .CNT_WIDTH(16)) dut (
    .i_arst(arst), .i_wclk(clk), .i_valid(valid), .o_ready(ready), .i_data(data),
    .i_flush(flush), .i_fifo_full(full), .o_fifo_we(we), .o_fifo_wdata(wdata),
    .o_word_cnt(cnt)
  );

  fifo_write_packer #(.IN_WIDTH(8), .RATIO(4), .CNT_WIDTH(4)) dut_cnt4 (
    .i_arst(arst), .i_wclk(clk), .i_valid(valid), .o_ready(ready2), .i_data(data),
    .i_flush(flush), .i_fifo_full(full), .o_fifo_we(we2), .o_fifo_wdata(wdata2),
    .o_word_cnt(cnt2)
  );

  // Every write seen on the FIFO port is checked against the oldest expected word.
  always @(negedge clk) begin
    if (!arst && we === 1'b1) begin
      logic [31:0] e;
      n_writes++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%h required=no_write", wdata);
      end else begin
        e = exp_q.pop_front();
        if (wdata !== e) begin
          bad++;
          $display("FAIL write_data got=%h required=%h", wdata, e);
        end
      end
    end
  end

  task automatic model_clear();
    exp_q.delete();
    exp_word = '0;
    lane = 0;
  endtask

  task automatic model_accept(input logic [7:0] d);
    exp_word[lane*8 +: 8] = d;
    lane++;
    if (lane == 4) begin
      exp_q.push_back(exp_word);
      exp_word = '0;
      lane = 0;
    end
  endtask

  task automatic apply_reset();
    arst = 1'b1; valid = 1'b0; flush = 1'b0; full = 1'b0; data = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    n_writes = 0;
  endtask

  task automatic idle(input int unsigned n);
    valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one beat; entered and left 1 time unit after a rising edge.
  task automatic drive_beat(input logic [7:0] d);
    int unsigned n = 0;
    valid = 1'b1; data = d;
    @(negedge clk);
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL beat_timeout got=ready_low required=accept data=%h", d);
    end else begin
      model_accept(d);
    end
    @(posedge clk);
    #1 valid = 1'b0; data = 8'($urandom);
  endtask

  task automatic check_drained(input string name, input logic [15:0] exp_cnt);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s_drain got=%0d_left required=0", name, exp_q.size());
    end
    total++;
    if (cnt !== exp_cnt) begin
      bad++;
      $display("FAIL %s_cnt got=%0d required=%0d", name, cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    arst = 1'b1; valid = 1'b1; flush = 1'b0; full = 1'b0; data = 8'h5A;
    model_clear();
    repeat (2) @(negedge clk);
    total++;
    if (ready !== 1'b1 || we !== 1'b0 || wdata !== 32'h0 || cnt !== 16'h0 || cnt2 !== 4'h0) begin
      bad++;
      $display("FAIL reset_state got=rdy%b we%b wd%h cnt%0d required=rdy1 we0 wd0 cnt0",
               ready, we, wdata, cnt);
    end
    @(posedge clk);
    #1 valid = 1'b0; arst = 1'b0;
    n_writes = 0;
  endtask

  task automatic test_basic();
    apply_reset();
    drive_beat(8'h11); drive_beat(8'h22); drive_beat(8'h33); drive_beat(8'h44);
    @(negedge clk);
    total++;
    if (we !== 1'b1 || wdata !== 32'h44332211) begin
      bad++;
      $display("FAIL basic_latency got=we%b wd%h required=we1 wd44332211", we, wdata);
    end
    @(posedge clk); #1;
    idle(2);
    check_drained("basic", 16'd1);
  endtask

  task automatic test_backpressure();
    apply_reset();
    full = 1'b1;
    for (int i = 0; i < 8; i++) begin
      valid = 1'b1; data = 8'(i + 1);
      @(negedge clk);
      total++;
      if (ready !== (i < 7) || we !== 1'b0) begin
        bad++;
        $display("FAIL bp_ready beat=%0d got=rdy%b we%b required=rdy%b we0", i, ready, we, i < 7);
      end
      if (ready === 1'b1) model_accept(8'(i + 1));
      if (i < 7) begin
        @(posedge clk); #1;
      end
    end
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (ready !== 1'b0 || we !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold got=rdy%b we%b required=rdy0 we0", ready, we);
      end
    end
    @(posedge clk); #1 full = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || we !== 1'b1) begin
      bad++;
      $display("FAIL bp_release got=rdy%b we%b required=rdy1 we1", ready, we);
    end
    model_accept(8'd8);
    @(posedge clk); #1 valid = 1'b0;
    idle(3);
    check_drained("bp", 16'd2);
  endtask

  task automatic test_stream();
    int unsigned stalls = 0;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      valid = 1'b1; data = 8'($urandom);
      @(negedge clk);
      if (ready !== 1'b1) stalls++;
      else model_accept(data);
      @(posedge clk); #1;
    end
    idle(3);
    total++;
    if (stalls != 0) begin
      bad++;
      $display("FAIL stream_ready got=%0d_stalls required=0", stalls);
    end
    total++;
    if (n_writes != 100) begin
      bad++;
      $display("FAIL stream_writes got=%0d required=100", n_writes);
    end
    check_drained("stream", 16'd100);
  endtask

  task automatic test_flush();
    apply_reset();
    drive_beat(8'hAA); drive_beat(8'hBB);
    flush = 1'b1;
`ifdef FIFO_WRITE_PACKER_FLUSH_EN
    exp_q.push_back(32'h0000BBAA);
    exp_word = '0; lane = 0;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    total++;
    if (we !== 1'b1 || wdata !== 32'h0000BBAA) begin
      bad++;
      $display("FAIL flush_word got=we%b wd%h required=we1 wd0000bbaa", we, wdata);
    end
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    idle(3);
    check_drained("flush_idle", 16'd1);
    drive_beat(8'h01); drive_beat(8'h02); drive_beat(8'h03); drive_beat(8'h04);
    idle(3);
    check_drained("flush_lane0", 16'd2);
`else
    @(posedge clk); #1 flush = 1'b0;
    idle(3);
    check_drained("noflush_ignored", 16'd0);
    drive_beat(8'hCC); drive_beat(8'hDD);
    idle(3);
    check_drained("noflush_word", 16'd1);
`endif
  endtask

  task automatic test_reset_midword();
    apply_reset();
    full = 1'b1;
    drive_beat(8'hA1); drive_beat(8'hA2); drive_beat(8'hA3); drive_beat(8'hA4);
    drive_beat(8'hB1); drive_beat(8'hB2);
    arst = 1'b1;
    model_clear();
    #2;
    total++;
    if (ready !== 1'b1 || we !== 1'b0 || wdata !== 32'h0 || cnt !== 16'h0) begin
      bad++;
      $display("FAIL midreset_state got=rdy%b we%b wd%h cnt%0d required=rdy1 we0 wd0 cnt0",
               ready, we, wdata, cnt);
    end
    full = 1'b0;
    @(posedge clk); #1 arst = 1'b0;
    idle(3);
    total++;
    if (n_writes != 0) begin
      bad++;
      $display("FAIL midreset_nowrite got=%0d required=0", n_writes);
    end
    drive_beat(8'h01); drive_beat(8'h02); drive_beat(8'h03); drive_beat(8'h04);
    idle(3);
    check_drained("midreset_lane0", 16'd1);
  endtask

  task automatic test_cnt_wrap();
    apply_reset();
    for (int i = 0; i < 68; i++) drive_beat(8'(i));
    idle(3);
    total++;
    if (cnt2 !== 4'd1) begin
      bad++;
      $display("FAIL cnt4_wrap got=%0d required=1", cnt2);
    end
    check_drained("cnt_wrap", 16'd17);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_stream();
    test_flush();
    test_reset_midword();
    test_cnt_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
